// File: rtl/exec_scoreboard_if.sv
// Retire/observe bundle between a PDP-8-style core under test and its execution scoreboard.
interface exec_scoreboard_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int WQ_DEPTH   = 4
);
  logic                    retire_vld;
  logic [2:0]              retire_op;
  logic [ADDR_WIDTH-1:0]   retire_ea;
  logic [DATA_WIDTH-1:0]   retire_operand;
  logic [DATA_WIDTH-1:0]   dut_acc;
  logic                    dut_link;
  logic [ADDR_WIDTH-1:0]   dut_pc;
  logic                    dut_wr_vld;
  logic [ADDR_WIDTH-1:0]   dut_wr_addr;
  logic [DATA_WIDTH-1:0]   dut_wr_data;
  logic                    stop_on_err;
  logic [DATA_WIDTH-1:0]   gold_acc;
  logic                    gold_link;
  logic [ADDR_WIDTH-1:0]   gold_pc;
  logic                    err_acc, err_link, err_pc, err_wr, err_ovf;
  logic [15:0]             err_count;
  logic [$clog2(WQ_DEPTH):0] wq_count;
  logic                    frozen;

  modport slave (
    input  retire_vld, retire_op, retire_ea, retire_operand,
           dut_acc, dut_link, dut_pc, dut_wr_vld, dut_wr_addr, dut_wr_data, stop_on_err,
    output gold_acc, gold_link, gold_pc, err_acc, err_link, err_pc, err_wr, err_ovf,
           err_count, wq_count, frozen
  );
  modport master (
    output retire_vld, retire_op, retire_ea, retire_operand,
           dut_acc, dut_link, dut_pc, dut_wr_vld, dut_wr_addr, dut_wr_data, stop_on_err,
    input  gold_acc, gold_link, gold_pc, err_acc, err_link, err_pc, err_wr, err_ovf,
           err_count, wq_count, frozen
  );
endinterface

// File: rtl/exec_scoreboard.sv
// Golden-model execution scoreboard: tracks acc/link/pc, matches observed writes via a FIFO.
// Optional macro EXEC_SB_PC_CHECK_EN enables the DUT PC comparison.
module exec_scoreboard #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int WQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
  input  logic clk,
  input  logic reset,
  exec_scoreboard_if.slave sb
);
  localparam int PW = $clog2(WQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] OP_AND = 3'd0, OP_TAD = 3'd1, OP_ISZ = 3'd2, OP_DCA = 3'd3,
                         OP_JMS = 3'd4, OP_JMP = 3'd5, OP_CLA = 3'd6;
  localparam logic [0:0] ST_RUN = 1'b0, ST_FROZEN = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  link_q, link_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  chk_q, chk_d;
  logic                  err_acc_q, err_acc_d, err_link_q, err_link_d, err_pc_q, err_pc_d;
  logic                  err_wr_q, err_wr_d, err_ovf_q, err_ovf_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] wq_addr_q [WQ_DEPTH];
  logic [DATA_WIDTH-1:0] wq_data_q [WQ_DEPTH];

  logic                  run, stay, full, empty, wr_op, push, pop, any_err;
  logic                  wr_bad, ovf, acc_bad, link_bad, pc_bad;
  logic [DATA_WIDTH:0]   tad_sum;
  logic [DATA_WIDTH-1:0] res, cmp_data;
  logic [ADDR_WIDTH-1:0] cmp_addr;

`ifndef EXEC_SB_PC_CHECK_EN
  logic unused_pc;
  assign unused_pc = ^sb.dut_pc;
`endif

  always_comb begin
    run     = (state_q == ST_RUN);
    full    = (cnt_q == CW'(WQ_DEPTH));
    empty   = (cnt_q == '0);
    wr_op   = sb.retire_vld && (sb.retire_op == OP_ISZ || sb.retire_op == OP_DCA ||
                                sb.retire_op == OP_JMS);
    tad_sum = {1'b0, acc_q} + {1'b0, sb.retire_operand};
    res     = '0;
    acc_d   = acc_q;
    link_d  = link_q;
    pc_d    = pc_q;
    if (run && sb.retire_vld) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
      unique case (sb.retire_op)
        OP_AND: acc_d = acc_q & sb.retire_operand;
        OP_TAD: begin
          acc_d  = tad_sum[DATA_WIDTH-1:0];
          link_d = link_q ^ tad_sum[DATA_WIDTH];
        end
        OP_ISZ: begin
          res = sb.retire_operand + DATA_WIDTH'(1);
          if (res == '0) pc_d = pc_q + ADDR_WIDTH'(2);
        end
        OP_DCA: begin
          res   = acc_q;
          acc_d = '0;
        end
        OP_JMS: begin
          res  = DATA_WIDTH'(pc_q + ADDR_WIDTH'(1));
          pc_d = sb.retire_ea + ADDR_WIDTH'(1);
        end
        OP_JMP: pc_d = sb.retire_ea;
        OP_CLA: begin
          acc_d  = '0;
          link_d = 1'b0;
        end
        default: ;
      endcase
    end

    // An empty FIFO compares against the same-cycle write, which then never enters the queue.
    cmp_addr = empty ? sb.dut_wr_addr : wq_addr_q[rd_ptr_q];
    cmp_data = empty ? sb.dut_wr_data : wq_data_q[rd_ptr_q];
    pop      = run && wr_op && !empty;
    push     = run && sb.dut_wr_vld && !(wr_op && empty) && (!full || pop);
    ovf      = run && sb.dut_wr_vld && full && !pop;
    wr_bad   = run && wr_op && ((empty && !sb.dut_wr_vld) ||
                                cmp_addr != sb.retire_ea || cmp_data != res);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    chk_d    = run && sb.retire_vld;
    acc_bad  = chk_q && (sb.dut_acc != acc_q);
    link_bad = chk_q && (sb.dut_link != link_q);
`ifdef EXEC_SB_PC_CHECK_EN
    pc_bad   = chk_q && (sb.dut_pc != pc_q);
`else
    pc_bad   = 1'b0;
`endif

    any_err = err_acc_q | err_link_q | err_pc_q | err_wr_q | err_ovf_q;
    state_d = state_q;
    if (run && any_err && sb.stop_on_err) state_d = ST_FROZEN;
    stay    = (state_d == ST_RUN);
    err_acc_d  = stay && acc_bad;
    err_link_d = stay && link_bad;
    err_pc_d   = stay && pc_bad;
    err_wr_d   = stay && wr_bad;
    err_ovf_d  = stay && ovf;
    err_count_d = err_count_q;
    if (run && any_err && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      acc_q       <= '0;
      link_q      <= 1'b0;
      pc_q        <= START_ADDR;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      chk_q       <= 1'b0;
      err_acc_q   <= 1'b0;
      err_link_q  <= 1'b0;
      err_pc_q    <= 1'b0;
      err_wr_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      link_q      <= link_d;
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      err_acc_q   <= err_acc_d;
      err_link_q  <= err_link_d;
      err_pc_q    <= err_pc_d;
      err_wr_q    <= err_wr_d;
      err_ovf_q   <= err_ovf_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wq_addr_q[wr_ptr_q] <= sb.dut_wr_addr;
      wq_data_q[wr_ptr_q] <= sb.dut_wr_data;
    end
  end

  assign sb.gold_acc  = acc_q;
  assign sb.gold_link = link_q;
  assign sb.gold_pc   = pc_q;
  assign sb.err_acc   = err_acc_q;
  assign sb.err_link  = err_link_q;
  assign sb.err_pc    = err_pc_q;
  assign sb.err_wr    = err_wr_q;
  assign sb.err_ovf   = err_ovf_q;
  assign sb.err_count = err_count_q;
  assign sb.wq_count  = cnt_q;
  assign sb.frozen    = (state_q == ST_FROZEN);
endmodule
